// File: rtl/seq_scan_ctrl_if.sv
// Word-in / result-out handshake bundle for seq_scan_ctrl.
interface seq_scan_ctrl_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_hit;

    // Producer/consumer side
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_count, out_hit
    );

    // Controller side
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_count, out_hit
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Word-level controller: scans one word MSB-first through a 1-4 bit
// pattern matcher and returns the saturating per-word match count.
module seq_scan_ctrl #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           cfg_pattern,
    input  logic [2:0]           cfg_len,
    input  logic                 cfg_overlap,
    seq_scan_ctrl_if.slave       bus,
    output logic                 busy
);
    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bitcnt;
    logic [3:0]        r_hist;
    logic [2:0]        r_seen;
    logic [CNT_W-1:0]  r_count;
    logic              r_hit;
    logic [3:0]        r_pat;
    logic [2:0]        r_len;
    logic              r_ovl;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [2:0]        w_len_eff;
    logic              w_bit;
    logic [3:0]        w_hist_new;
    logic [2:0]        w_seen_new;
    logic [3:0]        w_mask;
    logic              w_match;
    logic [CNT_W-1:0]  w_count_new;

    // Effective length: anything outside 1..4 is treated as 4
    assign w_len_eff = (cfg_len >= 3'd1 && cfg_len <= 3'd4) ? cfg_len : 3'd4;

    // Match evaluation for the bit consumed this cycle
    always_comb begin
        w_bit      = r_shift[WORD_W-1];
        w_hist_new = {r_hist[2:0], w_bit};
        w_seen_new = (r_seen >= 3'd4) ? 3'd4 : r_seen + 3'd1;
        case (r_len)
            3'd1:    w_mask = 4'b0001;
            3'd2:    w_mask = 4'b0011;
            3'd3:    w_mask = 4'b0111;
            default: w_mask = 4'b1111;
        endcase
        w_match     = (w_seen_new >= r_len) && ((w_hist_new & w_mask) == (r_pat & w_mask));
        w_count_new = (w_match && r_count != CNT_MAX) ? r_count + CNT_W'(1) : r_count;
    end

    // Controller FSM with registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_hist      <= '0;
            r_seen      <= '0;
            r_count     <= '0;
            r_hit       <= 1'b0;
            r_pat       <= '0;
            r_len       <= '0;
            r_ovl       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_shift    <= bus.in_word;
                        r_pat      <= cfg_pattern;
                        r_len      <= w_len_eff;
                        r_ovl      <= cfg_overlap;
                        r_bitcnt   <= '0;
                        r_hist     <= '0;
                        r_seen     <= '0;
                        r_count    <= '0;
                        r_hit      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift  <= {r_shift[WORD_W-2:0], 1'b0};
                    r_hist   <= w_hist_new;
                    r_seen   <= (w_match && !r_ovl) ? 3'd0 : w_seen_new;
                    r_count  <= w_count_new;
                    r_hit    <= (w_count_new != '0);
                    r_bitcnt <= r_bitcnt + BIT_W'(1);
                    if (r_bitcnt == BIT_W'(WORD_W - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_count = r_count;
    assign bus.out_hit   = r_hit;
    assign busy          = r_busy;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed self-checking bench for seq_scan_ctrl (WORD_W=8, CNT_W=3).
module tb_seq_scan_ctrl;
    localparam int unsigned WORD_W = 8;
    localparam int unsigned CNT_W  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cfg_pattern;
    logic [2:0] cfg_len;
    logic       cfg_overlap;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .bus         (bus.slave),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present a word at a negedge, let it be accepted, drop in_valid
    task automatic accept(input logic [7:0] w, input logic [3:0] p, input logic [2:0] l,
                          input logic o, input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
        cfg_pattern  = p;
        cfg_len      = l;
        cfg_overlap  = o;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Wait for out_valid (bounded) and check latency and result
    task automatic wait_result(input int exp_cnt, input string tag);
        int lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(WORD_W));
        check({tag, "_count"}, 32'(bus.out_count), 32'(exp_cnt));
        check({tag, "_hit"}, 32'(bus.out_hit), 32'(exp_cnt != 0));
    endtask

    // Consume the result and confirm return to IDLE
    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_low"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_word  = '0;
        bus.out_ready = 1'b0;
        cfg_pattern  = 4'b0000;
        cfg_len      = 3'd4;
        cfg_overlap  = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_out_hit", 32'(bus.out_hit), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Overlapping matches: 1011 found at bits 4 and 7
        accept(8'b1011_0111, 4'b1011, 3'd4, 1'b1, "ovl");
        check("ovl_busy", 32'(busy), 32'd1);
        wait_result(2, "ovl");
        release_result("ovl");

        // Non-overlapping: restart after first match
        accept(8'b1011_0111, 4'b1011, 3'd4, 1'b0, "novl");
        wait_result(1, "novl");
        release_result("novl");

        // len=1 on all ones: 8 matches saturate at 7
        accept(8'hFF, 4'b0001, 3'd1, 1'b1, "sat");
        wait_result(7, "sat");
        release_result("sat");

        // len=0 treated as 4: 1111 matches at bits 4..8
        accept(8'hFF, 4'b1111, 3'd0, 1'b1, "len0");
        wait_result(5, "len0");
        release_result("len0");

        // Mid-word config change is ignored
        accept(8'b1011_0000, 4'b1011, 3'd4, 1'b1, "cfg");
        cfg_pattern = 4'b0000;
        cfg_overlap = 1'b1;
        wait_result(1, "cfg");
        release_result("cfg");
        // Next word picks up pattern 0000: matches at bits 4..8
        accept(8'h00, 4'b0000, 3'd4, 1'b1, "cfg_next");
        wait_result(5, "cfg_next");
        release_result("cfg_next");

        // Backpressure: hold result, ignore a pending word
        accept(8'b1011_0111, 4'b1011, 3'd4, 1'b1, "bp");
        wait_result(2, "bp");
        bus.in_valid = 1'b1;
        bus.in_word  = 8'hFF;
        cfg_pattern  = 4'b1111;
        cfg_len      = 3'd4;
        cfg_overlap  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_count", 32'(bus.out_count), 32'd2);
            check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        release_result("bp");
        // Pending word accepted back-to-back
        accept(8'hFF, 4'b1111, 3'd4, 1'b1, "b2b");
        wait_result(5, "b2b");
        release_result("b2b");

        // Async reset in the middle of a word
        accept(8'b1011_0111, 4'b1011, 3'd4, 1'b1, "arst");
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_count", 32'(bus.out_count), 32'd0);
        check("arst_out_hit", 32'(bus.out_hit), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        check("arst_no_result", 32'(seen_valid), 32'd0);
        accept(8'b1011_0111, 4'b1011, 3'd4, 1'b1, "post");
        wait_result(2, "post");
        release_result("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Word-level controller for bit-serial sequence detection. Accepts parallel words over a valid/ready handshake and shifts each word MSB-first through an internal programmable pattern matcher (1–4 bits, overlapping or non-overlapping). It counts matches per word and returns the result over a second valid/ready handshake. It sits between a parallel producer and the bit-serial detection path, sequencing that path one word at a time.

## Interface
- WORD_W, 8, bits per input word (≥4)
- CNT_W, 4, width of per-word match count (≥1)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- cfg_pattern  input  4  pattern; bit [cfg_len-1] is the first bit expected in time
- cfg_len  input  3  pattern length 1–4; values 0 and 5–7 are treated as 4
- cfg_overlap  input  1  1 = overlapping matches, 0 = restart after each match
- in_valid  input  1  in_word valid
- in_ready  output  1  controller can accept a word
- in_word  input  WORD_W  word to scan, MSB first
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_count  output  CNT_W  matches found in the word (saturating)
- out_hit  output  1  out_count != 0
- busy  output  1  state != IDLE

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on in_valid && in_ready.
  - SHIFT → REPORT after WORD_W bits have been consumed.
  - REPORT → IDLE on out_valid && out_ready.
- in_ready = (state == IDLE). There is no pipelining: only one word is in flight at a time.
- On accept, the controller latches:
  - in_word into the shift register,
  - cfg_pattern, effective cfg_len and cfg_overlap into shadow registers; config changes mid-word are ignored,
  - clears history (4 bits), seen-count (0–4) and match count.
- Each SHIFT cycle, the controller consumes one bit b, starting at in_word[WORD_W-1]:
  - history ← {history[2:0], b}
  - seen ← min(seen+1, 4)
  - A match occurs when seen_new ≥ len and history_new[len-1:0] == pattern[len-1:0].
  - On a match, count increments and saturates at 2^CNT_W−1.
  - If overlap=0, seen resets to 0 on a match. History may keep its stale bits because the seen gate masks them.
- Matches never span words; the history is cleared at every accept.
- In REPORT: out_valid=1 and out_count/out_hit come from registers. Both are held stable while out_ready=0.
- Reset (any time, including mid-SHIFT or mid-REPORT): state goes to IDLE and all registers clear. Any partial word is discarded and no result is emitted for it.

## Timing
- Reset values: in_ready=1, out_valid=0, out_count=0, out_hit=0, busy=0.
- The accept edge is T0. Bits are consumed at edges T0+1 … T0+WORD_W. out_valid rises after edge T0+WORD_W, so the first valid cycle is WORD_W cycles after the accept.
- out_valid stays high until the cycle where out_ready=1. The FSM is in IDLE after that edge, and in_ready=1 in the following cycle.
- Minimum word period is WORD_W+2 cycles when out_ready is tied high.
- in_valid while busy is ignored; the producer must hold in_valid and in_word until in_ready.
- out_valid does not depend combinationally on out_ready. in_ready does not depend combinationally on in_valid.

## Test plan
- Overlap: pattern=4'b1011, len=4, overlap=1, word=8'b1011_0111 → out_count=2, out_hit=1, with out_valid exactly 8 cycles after accept.
- Non-overlap: same pattern and word with overlap=0 → out_count=1.
- Saturation and short pattern (CNT_W=3): pattern=4'b0001, len=1, overlap=1, word=8'hFF → out_count=7. Then len=0 (treated as 4), pattern=4'b1111, word=8'hFF, overlap=1 → out_count=5.
- Config latch: accept word 8'b1011_0000 with pattern 1011/len=4, then change cfg_pattern to 4'b0000 during SHIFT → out_count=1. The next word uses the new config.
- Backpressure and handshake: hold out_ready=0 for 5 cycles → out_valid and out_count stay stable, and in_ready=0 with in_valid=1 ignored. Release out_ready → in_ready=1 on the next cycle, and a back-to-back word is accepted.
- Async reset: assert reset_n=0 mid-cycle at bit 4 of a word → outputs go to reset values immediately with no clock edge. After release, no out_valid appears for the aborted word, and a new word is scanned correctly.
